pixel_stream_tx: RTL and testbench
==================================

PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 The block SHALL expose these parameters:
- width, default 640, active pixels per line.
- height, default 480, active lines per frame.
- hblank, default 16, blank cycles per line; must be >= 1.
- vblank, default 2, blank lines per frame; must be >= 1.
- fifo_depth, default 16, pixel FIFO entries; must be a power of 2.

REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin streaming frames.
- stop  in  1  stop after the current frame ends.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  FIFO can accept a pixel.
- in_data  in  `PIXEL_SIZE  upstream pixel {B,G,R}.
- hsync  out  1  line marker.
- vsync  out  1  frame marker.
- en  out  1  active-pixel qualifier.
- data  out  `PIXEL_SIZE  output pixel.
- busy  out  1  streaming in progress.
- underflow  out  1  sticky: an active slot found the FIFO empty.

Function
REQ-003 A pixel SHALL be pushed into the FIFO on any cycle where in_valid && in_ready; in_ready SHALL be 1 whenever the FIFO is not full.
- A push and a pop in the same cycle SHALL both occur and leave the occupancy unchanged.

REQ-004 The FSM SHALL have two states, IDLE and RUN.
- IDLE->RUN on start; hcnt and vcnt are both set to 0.
- RUN->IDLE at the last cycle of a frame if a stop request is pending.

REQ-005 A stop pulse SHALL latch a stop request that is cleared on entry to IDLE.
- If start and stop are both high in IDLE, the block SHALL enter RUN with the stop request latched, so exactly one frame is streamed.

REQ-006 In RUN, hcnt SHALL count 0..hblank+width-1 and wrap.
- vcnt SHALL increment on each hcnt wrap, counting 0..vblank+height-1.
- On vcnt wrap, the next frame SHALL start immediately with no gap.

REQ-007 A slot SHALL be active when vcnt >= vblank and hcnt >= hblank.
- In an active slot, the block SHALL pop one FIFO entry.

REQ-008 All outputs SHALL be registered, appearing one cycle after the counter state that produces them:
- hsync=1 when hcnt==0.
- vsync=1 throughout vcnt==0.
- en=1 for active slots.
- data=popped pixel when en=1, else 0.

REQ-009 On an active slot with the FIFO empty:
- en SHALL still be 1, data SHALL be 0, and underflow SHALL set; raster timing SHALL be unaffected.
- underflow SHALL clear only on reset or on the IDLE->RUN transition.

REQ-010 busy SHALL be 1 in RUN and 0 in IDLE. In IDLE, hsync, vsync, en and data SHALL be 0.

REQ-011 start while in RUN SHALL be ignored.

REQ-012 FIFO contents SHALL be retained across IDLE, so pixels preloaded before start are used.

Reset
REQ-013 Reset SHALL override all other inputs and, on the next edge, set:
- state=IDLE, hcnt=vcnt=0, FIFO empty, stop request clear.
- Outputs: hsync=vsync=en=busy=underflow=0, data=0, in_ready=1.

REQ-014 Reset asserted mid-frame SHALL abort the frame; the stream SHALL be silent until a new start.

Configuration
REQ-015 Macro PIXEL_TX_TEST_PATTERN_EN:
- When defined, the block SHALL add input pattern_sel (1 bit).
- With pattern_sel=1, active-slot data SHALL be {3{hcnt-hblank truncated to `WORD_SIZE}} (horizontal gray ramp), the FIFO SHALL NOT be popped, and underflow SHALL NOT set.
- When the macro is undefined, the port and the pattern logic SHALL be absent.

Structure
REQ-016 `PIXEL_SIZE and `WORD_SIZE SHALL come from global.vh; FSM state encodings SHALL be defined there as IDLE/RUN constants.

REQ-017 The FIFO SHALL be a separate sub-module, pixel_fifo (parameters WIDTH, DEPTH; ports push/pop/full/empty), instantiated once.

Verification
All scenarios use width=4, height=2, hblank=2, vblank=1 (6-cycle lines, 18-cycle frames).

REQ-018 Preload 8 pixels 1..8, then pulse start -> busy=1 next cycle; first hsync=vsync=1 one cycle later; en pattern 001111 on lines 1-2; data 1,2,3,4 then 5,6,7,8.

REQ-019 start with FIFO empty -> en timing unchanged, data=0, underflow=1 from the first active slot; a second start after IDLE clears it.

REQ-020 Pulse stop mid-frame 1 -> frame completes all 18 cycles, then busy=0 and all outputs 0.

REQ-021 Push with in_valid=1 continuously while streaming -> no pixel lost or duplicated; in_ready=0 only when 16 entries are held; simultaneous push and pop at full accepted.

REQ-022 Assert reset at cycle 7 of a frame -> next cycle all outputs 0, in_ready=1, FIFO empty; start and stop pulsed together afterward -> exactly one frame is streamed.

REQ-023 With PIXEL_TX_TEST_PATTERN_EN and pattern_sel=1 -> active data 000000,010101,020202,030303 (hex) per line; FIFO occupancy unchanged.

Source files
------------

// File: rtl/pixel_stream_tx_pkg.sv
// pixel_stream_tx_pkg
// Shared types and constants for the pixel stream transmitter.
//   tx_state_t : FSM state encoding (IDLE / RUN)
//   pixel_t    : one {B,G,R} pixel, `PIXEL_SIZE bits wide
//   cnt_width  : bits needed to hold a counter running 0..n-1
// `PIXEL_SIZE / `WORD_SIZE normally arrive from global.vh; the guarded
// defaults below keep this slice self-contained.
// Optional feature macro (used by pixel_stream_tx): PIXEL_TX_TEST_PATTERN_EN.

`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package pixel_stream_tx_pkg;

    localparam int PIXEL_W = `PIXEL_SIZE;
    localparam int WORD_W  = `WORD_SIZE;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

    typedef logic [PIXEL_W-1:0] pixel_t;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_stream_tx_if.sv
// pixel_stream_tx_if
// Bundles the upstream pixel handshake and the raster video output.
//   in_valid / in_ready / in_data : upstream pixel push handshake
//   hsync / vsync / en / data     : registered raster output
// Modports:
//   master : the side that feeds pixels and watches the video output
//   slave  : the transmitter itself

`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif

interface pixel_stream_tx_if;
    import pixel_stream_tx_pkg::*;

    logic   in_valid;
    logic   in_ready;
    pixel_t in_data;
    logic   hsync;
    logic   vsync;
    logic   en;
    pixel_t data;

    modport master (
        output in_valid, in_data,
        input  in_ready, hsync, vsync, en, data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, hsync, vsync, en, data
    );

endinterface

// File: rtl/pixel_fifo.sv
// pixel_fifo
// Show-ahead synchronous FIFO holding upstream pixels.
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   push/wdata : write request; accepted when not full, or when full and
//                a pop happens in the same cycle
//   pop        : read request; ignored when empty
//   rdata      : head entry, valid whenever empty=0
//   full/empty : occupancy flags
// DEPTH must be a power of 2 and at least 2 so the pointers wrap naturally.

module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO may still take a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx
// Streams buffered pixels out as a raster: hblank blank cycles then width
// active cycles per line, vblank blank lines then height active lines per
// frame. Frames repeat back to back until a stop request ends the stream at
// a frame boundary.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   start       : begin streaming (ignored while running)
//   stop        : end the stream after the current frame
//   bus (slave) : in_valid/in_ready/in_data pixel input,
//                 hsync/vsync/en/data registered video output
//   busy        : high while streaming
//   underflow   : sticky, an active slot found the FIFO empty
//   pattern_sel : (PIXEL_TX_TEST_PATTERN_EN only) send a horizontal gray
//                 ramp instead of FIFO pixels
// Optional feature macro: PIXEL_TX_TEST_PATTERN_EN.

`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module pixel_stream_tx
    import pixel_stream_tx_pkg::*;
#(
    parameter int width      = 640,
    parameter int height     = 480,
    parameter int hblank     = 16,
    parameter int vblank     = 2,
    parameter int fifo_depth = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
`ifdef PIXEL_TX_TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    pixel_stream_tx_if.slave  bus,
    output logic              busy,
    output logic              underflow
);

    localparam int H_TOTAL = hblank + width;
    localparam int V_TOTAL = vblank + height;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_BLANK = HW'(hblank);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_BLANK = VW'(vblank);

    tx_state_t      state;
    logic [HW-1:0]  hcnt;
    logic [VW-1:0]  vcnt;
    logic           stop_req;

    logic           hsync_q;
    logic           vsync_q;
    logic           en_q;
    pixel_t         data_q;

    logic           active;
    logic           use_pattern;
    pixel_t         pattern_px;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    pixel_t         fifo_rdata;
    pixel_t         slot_data;
    logic           frame_last;

    assign active     = (state == RUN) && (vcnt >= V_BLANK) && (hcnt >= H_BLANK);
    assign frame_last = (hcnt == H_LAST) && (vcnt == V_LAST);

`ifdef PIXEL_TX_TEST_PATTERN_EN
    logic [WORD_W-1:0] ramp;
    // Ramp value is the column index within the active part of the line.
    assign ramp        = WORD_W'(hcnt - H_BLANK);
    assign use_pattern = pattern_sel;
    assign pattern_px  = {3{ramp}};
`else
    assign use_pattern = 1'b0;
    assign pattern_px  = '0;
`endif

    // Test-pattern slots leave the FIFO alone; empty slots pop nothing.
    assign fifo_pop     = active && !use_pattern && !fifo_empty;
    assign bus.in_ready = !fifo_full || fifo_pop;
    assign fifo_push    = bus.in_valid && bus.in_ready;

    always_comb begin
        slot_data = '0;
        if (active) begin
            if (use_pattern) begin
                slot_data = pattern_px;
            end else if (!fifo_empty) begin
                slot_data = fifo_rdata;
            end
        end
    end

    pixel_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Raster FSM. Outputs are registered from the counter state of the
    // current cycle, so they trail the counters by one clock. A stop that
    // arrives on the final cycle of a frame still takes effect there.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hcnt      <= '0;
            vcnt      <= '0;
            stop_req  <= 1'b0;
            busy      <= 1'b0;
            underflow <= 1'b0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            en_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    hsync_q <= 1'b0;
                    vsync_q <= 1'b0;
                    en_q    <= 1'b0;
                    data_q  <= '0;
                    hcnt    <= '0;
                    vcnt    <= '0;
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        underflow <= 1'b0;
                        stop_req  <= stop;
                    end
                end
                RUN: begin
                    hsync_q <= (hcnt == '0);
                    vsync_q <= (vcnt == '0);
                    en_q    <= active;
                    data_q  <= slot_data;
                    if (active && !use_pattern && fifo_empty) begin
                        underflow <= 1'b1;
                    end
                    if (stop) begin
                        stop_req <= 1'b1;
                    end
                    if (frame_last && (stop_req || stop)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        stop_req <= 1'b0;
                        hcnt     <= '0;
                        vcnt     <= '0;
                    end else if (hcnt == H_LAST) begin
                        hcnt <= '0;
                        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.hsync = hsync_q;
    assign bus.vsync = vsync_q;
    assign bus.en    = en_q;
    assign bus.data  = data_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx
// Self-checking bench for pixel_stream_tx with a 4x2 active raster,
// hblank=2, vblank=1 (6-cycle lines, 18-cycle frames), FIFO depth 16.
// A reference model keeps the FIFO as a queue and the raster position as a
// single frame-cycle index; expected outputs come from that model.
// Optional feature macro: PIXEL_TX_TEST_PATTERN_EN.

`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif

module tb_pixel_stream_tx;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int HB    = 2;
    localparam int VB    = 1;
    localparam int DEPTH = 16;
    localparam int HT    = W + HB;
    localparam int VT    = H + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic stop;
    logic busy;
    logic underflow;
    logic patternSel;

    pixel_stream_tx_if bus();

    pixel_stream_tx #(
        .width      (W),
        .height     (H),
        .hblank     (HB),
        .vblank     (VB),
        .fifo_depth (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
`ifdef PIXEL_TX_TEST_PATTERN_EN
        .pattern_sel (patternSel),
`endif
        .bus         (bus),
        .busy        (busy),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    logic [23:0] mQ[$];
    bit          mRun;
    int          mK;
    bit          mStop;
    bit          mUf;
    bit          mBusy;
    bit          mHs;
    bit          mVs;
    bit          mEn;
    logic [23:0] mData;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual %0h required %0h at t=%0t",
                     tag, actual, expected, $time);
        end
    endtask

    function automatic bit slotActive(input int k);
        return ((k / HT) >= VB) && ((k % HT) >= HB);
    endfunction

    // Advance the model by one clock edge using the inputs held for that edge.
    task automatic modelEdge();
        bit          act;
        bit          popping;
        bit          pushing;
        logic [7:0]  ramp;
        if (reset) begin
            mRun  = 0;
            mK    = 0;
            mStop = 0;
            mUf   = 0;
            mBusy = 0;
            mHs   = 0;
            mVs   = 0;
            mEn   = 0;
            mData = '0;
            mQ.delete();
            return;
        end
        act     = mRun && slotActive(mK);
        popping = act && !patternSel && (mQ.size() > 0);
        pushing = bus.in_valid && ((mQ.size() < DEPTH) || popping);
        mHs     = mRun && ((mK % HT) == 0);
        mVs     = mRun && ((mK / HT) == 0);
        mEn     = act;
        mData   = '0;
        if (act) begin
            if (patternSel) begin
                ramp  = 8'((mK % HT) - HB);
                mData = {ramp, ramp, ramp};
            end else if (mQ.size() > 0) begin
                mData = mQ[0];
            end else begin
                mUf = 1;
            end
        end
        if (popping) begin
            void'(mQ.pop_front());
        end
        if (pushing) begin
            mQ.push_back(bus.in_data);
        end
        if (mRun) begin
            if (stop) begin
                mStop = 1;
            end
            if ((mK == FRAME - 1) && mStop) begin
                mRun  = 0;
                mBusy = 0;
                mStop = 0;
                mK    = 0;
            end else begin
                mK = (mK + 1) % FRAME;
            end
        end else if (start) begin
            mRun  = 1;
            mBusy = 1;
            mK    = 0;
            mUf   = 0;
            mStop = stop;
        end
    endtask

    task automatic compareAll();
        bit popNow;
        bit expReady;
        popNow   = mRun && slotActive(mK) && !patternSel && (mQ.size() > 0);
        expReady = (mQ.size() < DEPTH) || popNow;
        checkOutput("busy",      32'(busy),         32'(mBusy));
        checkOutput("hsync",     32'(bus.hsync),    32'(mHs));
        checkOutput("vsync",     32'(bus.vsync),    32'(mVs));
        checkOutput("en",        32'(bus.en),       32'(mEn));
        checkOutput("data",      32'(bus.data),     32'(mData));
        checkOutput("underflow", 32'(underflow),    32'(mUf));
        checkOutput("in_ready",  32'(bus.in_ready), 32'(expReady));
    endtask

    task automatic applyStimulus(input bit st, input bit sp, input bit iv,
                                 input logic [23:0] d, input bit rs);
        start        = st;
        stop         = sp;
        bus.in_valid = iv;
        bus.in_data  = d;
        reset        = rs;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, '0, 0);
        end
    endtask

    initial begin
        logic [23:0] seq;
        start        = 0;
        stop         = 0;
        reset        = 1;
        patternSel   = 0;
        bus.in_valid = 0;
        bus.in_data  = '0;

        $display("[TB] reset");
        applyStimulus(0, 0, 0, '0, 1);
        applyStimulus(0, 0, 0, '0, 1);
        idleCycles(2);

        $display("[TB] preload 1..8 then one frame");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 0, 1, 24'(i), 0);
        end
        applyStimulus(1, 0, 0, '0, 0);
        for (int c = 0; c < FRAME; c++) begin
            applyStimulus(0, c == 5, 0, '0, 0);
        end
        idleCycles(3);

        $display("[TB] start with empty FIFO");
        applyStimulus(1, 1, 0, '0, 0);
        idleCycles(FRAME + 2);
        applyStimulus(1, 1, 0, '0, 0);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 0, 1, 24'(24'h100 + c), 0);
        end
        idleCycles(FRAME);

        $display("[TB] continuous push while streaming");
        applyStimulus(0, 0, 0, '0, 1);
        seq = 24'h000a00;
        applyStimulus(1, 0, 1, seq, 0);
        for (int c = 0; c < 3 * FRAME; c++) begin
            seq++;
            applyStimulus(0, c == 2 * FRAME, 1, seq, 0);
        end
        idleCycles(FRAME + 2);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 24'(24'h300 + i), 0);
        end
        applyStimulus(1, 0, 0, '0, 0);
        idleCycles(7);
        applyStimulus(0, 0, 0, '0, 1);
        idleCycles(4);
        applyStimulus(1, 1, 0, '0, 0);
        idleCycles(FRAME + 3);

`ifdef PIXEL_TX_TEST_PATTERN_EN
        $display("[TB] test pattern");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 24'(24'h500 + i), 0);
        end
        patternSel = 1;
        applyStimulus(1, 1, 0, '0, 0);
        idleCycles(FRAME + 2);
        patternSel = 0;
        applyStimulus(1, 1, 0, '0, 0);
        idleCycles(FRAME + 2);
`endif

        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) begin
            applyStimulus(($urandom % 40) == 0, ($urandom % 50) == 0,
                          ($urandom % 3) != 0, 24'($urandom),
                          ($urandom % 400) == 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
